// File: rtl/multi_adc_burst_reader.sv
// multi_adc_burst_reader: shared SCLK/CS burst readout of several serial ADCs into per-channel FIFOs
module multi_adc_burst_reader #(
    parameter int          pADC_CHANNELS = 4,
    parameter int          pFRAME_BITS   = 16,
    parameter int          pLEAD_BITS    = 2,
    parameter int          pADC_BITS     = 12,
    parameter int          pDATA_WIDTH   = 16,
    parameter int          pDIV_WIDTH    = 16,
    parameter int          pCONV_WIDTH   = 12,
    parameter int          pQUIET        = 4,
    parameter logic [7:0]  pACTIVE_EDGE  = "F"
) (
    input  logic                                 iCLK,
    input  logic                                 iRST,
    input  logic                                 iEN,
    input  logic                                 iSTART,
    input  logic [pCONV_WIDTH-1:0]               iCONV_NUM,
    input  logic [pDIV_WIDTH-1:0]                iCLK_DIV,
    input  logic                                 iTEST_MODE,
    output logic                                 oBUSY,
    output logic                                 oCOMPL,
    output logic                                 oERROR,
    output logic [pADC_CHANNELS-1:0]             oOVF,
    output logic                                 oSCLK,
    output logic                                 oCS,
    input  logic [pADC_CHANNELS-1:0]             iSDATA,
    output logic [pADC_CHANNELS-1:0]             oFIFO_WR,
    output logic [pADC_CHANNELS*pDATA_WIDTH-1:0] oFIFO_DATA,
    input  logic [pADC_CHANNELS-1:0]             iFIFO_AFULL
);
    localparam int   EW       = $clog2(2*pFRAME_BITS);
    localparam logic SAMP_LVL = (pACTIVE_EDGE == "F");
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, WRITE, QUIET, DONE} state_t;
    state_t                   state_q;
    logic                     cs_q, sclk_q, compl_q, err_q, test_q;
    logic [pADC_CHANNELS-1:0] ovf_q;
    logic [pDIV_WIDTH-1:0]    div_q, cnt_q;
    logic [EW-1:0]            edge_q;
    logic [pCONV_WIDTH-1:0]   conv_q, num_q;
    logic [pFRAME_BITS-1:0]   sh_q   [pADC_CHANNELS];
    logic [pDATA_WIDTH-1:0]   data_q [pADC_CHANNELS];
    logic [pADC_BITS-1:0]     pay    [pADC_CHANNELS];
    logic                     tick, quiet_end;
    assign tick      = cnt_q == div_q - pDIV_WIDTH'(1);
    assign quiet_end = cnt_q == pDIV_WIDTH'(pQUIET-1);
    always_comb
        for (int c = 0; c < pADC_CHANNELS; c++)
            pay[c] = test_q ? pADC_BITS'(conv_q) + pADC_BITS'(c) : sh_q[c][pFRAME_BITS-1-pLEAD_BITS -: pADC_BITS];
    assign oBUSY    = state_q != IDLE;
    assign oCOMPL   = compl_q;
    assign oERROR   = err_q;
    assign oOVF     = ovf_q;
    assign oSCLK    = sclk_q;
    assign oCS      = cs_q;
    assign oFIFO_WR = {pADC_CHANNELS{state_q == WRITE && iEN}} & ~iFIFO_AFULL;
    for (genvar g = 0; g < pADC_CHANNELS; g++)
        assign oFIFO_DATA[g*pDATA_WIDTH +: pDATA_WIDTH] = oFIFO_WR[g] ? pDATA_WIDTH'(pay[g]) : data_q[g];
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            compl_q <= 1'b0;
            err_q   <= 1'b0;
            test_q  <= 1'b0;
            ovf_q   <= '0;
            div_q   <= pDIV_WIDTH'(1);
            cnt_q   <= '0;
            edge_q  <= '0;
            conv_q  <= '0;
            num_q   <= '0;
            for (int c = 0; c < pADC_CHANNELS; c++) begin
                sh_q[c]   <= '0;
                data_q[c] <= '0;
            end
        end else begin
            compl_q <= 1'b0;
            if (!iEN) begin
                state_q <= IDLE;
                cs_q    <= 1'b1;
                sclk_q  <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (iSTART) begin
                        ovf_q  <= '0;
                        err_q  <= 1'b0;
                        num_q  <= iCONV_NUM;
                        div_q  <= iCLK_DIV == '0 ? pDIV_WIDTH'(1) : iCLK_DIV;
                        test_q <= iTEST_MODE;
                        conv_q <= '0;
                        cnt_q  <= '0;
                        if (iCONV_NUM == '0) begin
                            state_q <= DONE;
                            compl_q <= 1'b1;
                        end else begin
                            state_q <= CS_SETUP;
                            cs_q    <= 1'b0;
                        end
                    end
                    CS_SETUP: if (tick) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        edge_q  <= '0;
                    end else cnt_q <= cnt_q + pDIV_WIDTH'(1);
                    SHIFT: if (tick) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + EW'(1);
                        // sample the line value held just before the selected SCLK transition
                        if (sclk_q == SAMP_LVL)
                            for (int c = 0; c < pADC_CHANNELS; c++)
                                sh_q[c] <= {sh_q[c][pFRAME_BITS-2:0], iSDATA[c]};
                        if (edge_q == EW'(2*pFRAME_BITS-1)) begin
                            state_q <= WRITE;
                            cs_q    <= 1'b1;
                        end
                    end else cnt_q <= cnt_q + pDIV_WIDTH'(1);
                    WRITE: begin
                        for (int c = 0; c < pADC_CHANNELS; c++)
                            if (!iFIFO_AFULL[c]) data_q[c] <= pDATA_WIDTH'(pay[c]);
                        ovf_q   <= ovf_q | iFIFO_AFULL;
                        err_q   <= err_q | (|iFIFO_AFULL);
                        conv_q  <= conv_q + pCONV_WIDTH'(1);
                        cnt_q   <= '0;
                        state_q <= QUIET;
                    end
                    QUIET: if (quiet_end) begin
                        cnt_q <= '0;
                        if (conv_q == num_q) begin
                            state_q <= DONE;
                            compl_q <= 1'b1;
                        end else begin
                            state_q <= CS_SETUP;
                            cs_q    <= 1'b0;
                        end
                    end else cnt_q <= cnt_q + pDIV_WIDTH'(1);
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multi_adc_burst_reader.sv
// tb_multi_adc_burst_reader: falling- and rising-edge sampling instances driven side by side against one scoreboard
module tb_multi_adc_burst_reader;
    typedef struct {int ch; logic [15:0] w;} exp_t;
    logic        clk = 0, rst = 1, en = 1, start = 0, tm = 0;
    logic [11:0] conv_num = 0;
    logic [15:0] clk_div = 1;
    logic [3:0]  afull = 0, sd_f, sd_r;
    logic        busy_f, compl_f, err_f, sclk_f, cs_f;
    logic        busy_r, compl_r, err_r, sclk_r, cs_r;
    logic [3:0]  ovf_f, wr_f, ovf_r, wr_r;
    logic [63:0] data_f, data_r;
    logic [15:0] frame [4];
    int          idx_f = 16, idx_r = 16;
    int          n_assert = 0, n_fail = 0;
    exp_t        sb_f[$], sb_r[$];

    always #5 clk = ~clk;

    multi_adc_burst_reader dut_f (
        .iCLK(clk), .iRST(rst), .iEN(en), .iSTART(start), .iCONV_NUM(conv_num), .iCLK_DIV(clk_div),
        .iTEST_MODE(tm), .oBUSY(busy_f), .oCOMPL(compl_f), .oERROR(err_f), .oOVF(ovf_f), .oSCLK(sclk_f),
        .oCS(cs_f), .iSDATA(sd_f), .oFIFO_WR(wr_f), .oFIFO_DATA(data_f), .iFIFO_AFULL(afull));
    multi_adc_burst_reader #(.pACTIVE_EDGE("R")) dut_r (
        .iCLK(clk), .iRST(rst), .iEN(en), .iSTART(start), .iCONV_NUM(conv_num), .iCLK_DIV(clk_div),
        .iTEST_MODE(tm), .oBUSY(busy_r), .oCOMPL(compl_r), .oERROR(err_r), .oOVF(ovf_r), .oSCLK(sclk_r),
        .oCS(cs_r), .iSDATA(sd_r), .oFIFO_WR(wr_r), .oFIFO_DATA(data_r), .iFIFO_AFULL(afull));

    // ADC models: MSB out at CS fall and shifted on rising SCLK (for falling-edge capture), or
    // MSB out on the first falling SCLK and shifted on each fall (for rising-edge capture)
    always @(negedge cs_f) idx_f = 15;
    always @(posedge sclk_f) if (!cs_f) idx_f--;
    always @(negedge cs_r) idx_r = 16;
    always @(negedge sclk_r) if (!cs_r) idx_r--;
    always_comb
        for (int c = 0; c < 4; c++) begin
            sd_f[c] = (idx_f >= 0 && idx_f < 16) ? frame[c][idx_f] : 1'b0;
            sd_r[c] = (idx_r >= 0 && idx_r < 16) ? frame[c][idx_r] : 1'b0;
        end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [15:0] w);
        exp_t e;
        e.ch = c;
        e.w  = w;
        sb_f.push_back(e);
        sb_r.push_back(e);
    endtask

    task automatic pop_check(input bit r, input int c, input logic [15:0] got);
        exp_t e;
        int   sz = r ? sb_r.size() : sb_f.size();
        n_assert++;
        assert (sz > 0) else begin
            n_fail++;
            $error("FAIL unexpected_write dut%0d ch%0d: observed %0h expected no write", r, c, got);
        end
        if (sz > 0) begin
            e = r ? sb_r.pop_front() : sb_f.pop_front();
            chk($sformatf("fifo_word dut%0d", r), {16'(c), got}, {16'(e.ch), e.w});
        end
    endtask

    always @(negedge clk)
        for (int c = 0; c < 4; c++) begin
            if (wr_f[c]) pop_check(0, c, data_f[c*16 +: 16]);
            if (wr_r[c]) pop_check(1, c, data_r[c*16 +: 16]);
        end

    task automatic burst(input int conv, input int div, input bit tmode, input int afull_win, input int re_at,
                         output int wins, output int csl, output int cpl, output int cpl_r);
        int prev = 1;
        bit fin = 0;
        conv_num = 12'(conv);
        clk_div  = 16'(div);
        tm       = tmode;
        start    = 1;
        wins = 0; csl = 0; cpl = 0; cpl_r = 0;
        @(negedge clk);
        for (int i = 0; i < 20000 && !fin; i++) begin
            start = (i == re_at);
            if (i == re_at) begin
                conv_num = 12'd7;
                clk_div  = 16'd5;
            end
            if (!cs_f && prev == 1) begin
                wins++;
                afull = (wins == afull_win) ? 4'b0100 : 4'b0000;
            end
            prev   = int'(cs_f);
            csl   += int'(!cs_f);
            cpl   += int'(compl_f);
            cpl_r += int'(compl_r);
            if (!busy_f && !busy_r) fin = 1;
            else @(negedge clk);
        end
        afull = 0;
        start = 0;
        chk("burst_terminates", 64'(fin), 64'd1);
    endtask

    initial begin
        int wins, csl, cpl, cpl_r;
        for (int c = 0; c < 4; c++) frame[c] = 16'h2AF0;
        repeat (2) @(negedge clk);
        chk("reset_f", {cs_f, sclk_f, busy_f, compl_f, err_f, ovf_f, wr_f}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
        chk("reset_r", {cs_r, sclk_r, busy_r, compl_r, err_r, ovf_r, wr_r}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0});
        chk("reset_data_f", data_f, 64'h0);
        chk("reset_data_r", data_r, 64'h0);
        rst = 0;
        @(negedge clk);

        for (int c = 0; c < 4; c++) push(c, 16'h0ABC);
        burst(1, 2, 0, 0, -1, wins, csl, cpl, cpl_r);
        chk("t1_windows", 64'(wins), 64'd1);
        chk("t1_cs_low_cycles", 64'(csl), 64'd66);
        chk("t1_compl", 64'({cpl, cpl_r}), 64'({32'd1, 32'd1}));

        for (int c = 0; c < 4; c++) frame[c] = 16'($urandom);
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) push(c, {4'h0, frame[c][13:2]});
        burst(2, 3, 0, 0, -1, wins, csl, cpl, cpl_r);
        chk("rand_windows", 64'(wins), 64'd2);
        chk("rand_cs_low_cycles", 64'(csl), 64'd198);

        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++) push(c, 16'(k + c));
        burst(3, 1, 1, 0, -1, wins, csl, cpl, cpl_r);
        chk("tm_windows", 64'(wins), 64'd3);
        chk("tm_cs_low_cycles", 64'(csl), 64'd99);
        chk("tm_compl", 64'({cpl, cpl_r}), 64'({32'd1, 32'd1}));

        for (int k = 0; k < 3; k++)
            for (int c = 0; c < 4; c++)
                if (!(k == 1 && c == 2)) push(c, 16'(k + c));
        burst(3, 1, 1, 2, -1, wins, csl, cpl, cpl_r);
        chk("afull_ovf", {ovf_f, ovf_r}, {4'b0100, 4'b0100});
        chk("afull_err", {err_f, err_r}, 2'b11);

        for (int c = 0; c < 4; c++) frame[c] = 16'h2AF0;
        for (int c = 0; c < 4; c++) push(c, 16'h0ABC);
        burst(1, 1, 0, 0, 10, wins, csl, cpl, cpl_r);
        chk("busy_start_windows", 64'(wins), 64'd1);
        chk("busy_start_cs_low", 64'(csl), 64'd33);
        chk("busy_start_compl", 64'({cpl, cpl_r}), 64'({32'd1, 32'd1}));
        chk("start_clears_flags", {ovf_f, err_f, ovf_r, err_r}, 10'h0);

        for (int c = 0; c < 4; c++) push(c, 16'(c));
        burst(1, 0, 1, 0, -1, wins, csl, cpl, cpl_r);
        chk("div0_cs_low", 64'(csl), 64'd33);

        conv_num = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("conv0_compl", {compl_f, busy_f, cs_f, compl_r, busy_r, cs_r}, 6'b111_111);
        @(negedge clk);
        chk("conv0_after", {compl_f, busy_f, cs_f, compl_r, busy_r, cs_r}, 6'b001_001);

        conv_num = 2;
        clk_div  = 2;
        tm       = 0;
        start    = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        chk("en_in_shift", {cs_f, cs_r}, 2'b00);
        en = 0;
        @(negedge clk);
        chk("en_abort", {cs_f, sclk_f, busy_f, wr_f, cs_r, sclk_r, busy_r, wr_r}, {3'b110, 4'h0, 3'b110, 4'h0});
        en = 1;
        cpl = 0;
        csl = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cpl += int'(compl_f) + int'(compl_r);
            csl += int'(!cs_f) + int'(!cs_r);
        end
        chk("en_abort_quiet", 64'({cpl, csl}), 64'h0);

        chk("scoreboard_drained", 64'({sb_f.size(), sb_r.size()}), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
